// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - issues one masked, strided vector load/store as scalar element requests
// Load responses return in order; a lane-tag FIFO steers each one back into its lane slot.
module vector_mem_sequencer #(
   parameter int LANES     = 8,
   parameter int ELEM_W    = 64,
   parameter int MAX_OUTST = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    vec_valid_i,
   output logic                    vec_ready_o,
   input  logic                    vec_is_store_i,
   input  logic [63:0]             vec_base_i,
   input  logic [63:0]             vec_stride_i,
   input  logic [LANES-1:0]        vec_mask_i,
   input  logic [LANES*ELEM_W-1:0] vec_wdata_i,
   output logic                    mem_req_valid_o,
   input  logic                    mem_req_ready_i,
   output logic                    mem_req_we_o,
   output logic [63:0]             mem_req_addr_o,
   output logic [ELEM_W-1:0]       mem_req_wdata_o,
   input  logic                    mem_resp_valid_i,
   input  logic [ELEM_W-1:0]       mem_resp_rdata_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [LANES*ELEM_W-1:0] load_data_o
);

   localparam int IW = $clog2(LANES);
   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int OW = $clog2(MAX_OUTST + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [63:0]       base_q, base_d;
   logic [63:0]       stride_q, stride_d;
   logic [LANES-1:0]  mask_q, mask_d;
   logic [ELEM_W-1:0] wdata_q [LANES];
   logic [ELEM_W-1:0] wdata_d [LANES];
   logic [ELEM_W-1:0] load_data_q [LANES];
   logic [ELEM_W-1:0] load_data_d [LANES];
   logic [OW-1:0]     outst_q, outst_d;
   logic [IW-1:0]     tag_q [MAX_OUTST];
   logic [IW-1:0]     tag_d [MAX_OUTST];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

   logic [IW-1:0]     idx;
   logic [63:0]       elem_off;
   logic              issuing, full, req_fire, load_fire, resp_fire;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   // Lowest remaining lane goes first.
   always_comb begin
      idx = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask_q[i]) idx = IW'(i);
      end
   end

   assign full      = (outst_q == OW'(MAX_OUTST));
   assign issuing   = (state_q == S_ISSUE) && (|mask_q);
   assign elem_off  = {{(64-IW){1'b0}}, idx} * stride_q;

   assign mem_req_valid_o = issuing && (is_store_q || !full);
   assign mem_req_we_o    = issuing && is_store_q;
   assign mem_req_addr_o  = issuing ? base_q + elem_off : '0;
   assign mem_req_wdata_o = (issuing && is_store_q) ? wdata_q[idx] : '0;

   assign req_fire  = mem_req_valid_o && mem_req_ready_i;
   assign load_fire = req_fire && !is_store_q;
   // Responses outside an active load (e.g. stragglers after reset) are dropped.
   assign resp_fire = mem_resp_valid_i && (outst_q != '0) &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN));

   assign vec_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);

   for (genvar g = 0; g < LANES; g++) begin : g_pack
      assign load_data_o[g*ELEM_W +: ELEM_W] = load_data_q[g];
   end

   always_comb begin
      state_d     = state_q;
      is_store_d  = is_store_q;
      base_d      = base_q;
      stride_d    = stride_q;
      mask_d      = mask_q;
      wdata_d     = wdata_q;
      load_data_d = load_data_q;
      tag_d       = tag_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      case ({load_fire, resp_fire})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase

      if (load_fire) begin
         tag_d[wr_ptr_q] = idx;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (resp_fire) begin
         load_data_d[tag_q[rd_ptr_q]] = mem_resp_rdata_i;
         rd_ptr_d                     = ptr_inc(rd_ptr_q);
      end

      case (state_q)
         S_IDLE: begin
            if (vec_valid_i) begin
               state_d    = S_ISSUE;
               is_store_d = vec_is_store_i;
               base_d     = vec_base_i;
               stride_d   = vec_stride_i;
               mask_d     = vec_mask_i;
               for (int i = 0; i < LANES; i++) begin
                  wdata_d[i]     = vec_wdata_i[i*ELEM_W +: ELEM_W];
                  load_data_d[i] = '0;
               end
            end
         end
         S_ISSUE: begin
            if (req_fire) mask_d[idx] = 1'b0;
            if (mask_d == '0) begin
               if (is_store_q || outst_d == '0) state_d = S_DONE;
               else                             state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (outst_d == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         base_q     <= '0;
         stride_q   <= '0;
         mask_q     <= '0;
         outst_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < LANES; i++) begin
            wdata_q[i]     <= '0;
            load_data_q[i] <= '0;
         end
         for (int i = 0; i < MAX_OUTST; i++) tag_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         is_store_q  <= is_store_d;
         base_q      <= base_d;
         stride_q    <= stride_d;
         mask_q      <= mask_d;
         outst_q     <= outst_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wdata_q     <= wdata_d;
         load_data_q <= load_data_d;
         tag_q       <= tag_d;
      end
   end

   resp_without_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      !(mem_resp_valid_i && outst_q == '0 && ((state_q == S_ISSUE) || (state_q == S_DRAIN))));

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - scoreboard bench for vector_mem_sequencer with an in-order memory model
module tb_vector_mem_sequencer;

   localparam int LANES = 8;
   localparam int EW    = 64;
   localparam int MO    = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                vec_valid_i = 1'b0;
   logic                vec_ready_o;
   logic                vec_is_store_i = 1'b0;
   logic [63:0]         vec_base_i = '0;
   logic [63:0]         vec_stride_i = '0;
   logic [LANES-1:0]    vec_mask_i = '0;
   logic [LANES*EW-1:0] vec_wdata_i = '0;
   logic                mem_req_valid_o;
   logic                mem_req_ready_i = 1'b1;
   logic                mem_req_we_o;
   logic [63:0]         mem_req_addr_o;
   logic [EW-1:0]       mem_req_wdata_o;
   logic                mem_resp_valid_i = 1'b0;
   logic [EW-1:0]       mem_resp_rdata_i = '0;
   logic                busy_o;
   logic                done_o;
   logic [LANES*EW-1:0] load_data_o;

   vector_mem_sequencer #(.LANES(LANES), .ELEM_W(EW), .MAX_OUTST(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o), .vec_is_store_i(vec_is_store_i),
      .vec_base_i(vec_base_i), .vec_stride_i(vec_stride_i), .vec_mask_i(vec_mask_i),
      .vec_wdata_i(vec_wdata_i),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
      .mem_req_wdata_o(mem_req_wdata_o),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
      .busy_o(busy_o), .done_o(done_o), .load_data_o(load_data_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_t;

   typedef struct {
      int          due;
      logic [63:0] data;
   } rsp_t;

   req_t exp_q[$];
   rsp_t rsp_q[$];
   int   req_cyc[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;
   bit stall = 1'b0;
   int bench_out = 0;
   int stale_n = 0;
   int max_out = 0;
   int overlap = 0;
   bit          prev_stall = 1'b0;
   logic        prev_we;
   logic [63:0] prev_addr, prev_wdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rd_of(input logic [63:0] a);
      return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: random or fixed ready, in-order responses after lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         mem_req_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bench_out > max_out) max_out = bench_out;
         if (bench_out >= MO) chk("valid_while_full", mem_req_valid_o, 1'b0);
         if (prev_stall) begin
            chk("stall_valid", mem_req_valid_o, 1'b1);
            chk("stall_we", mem_req_we_o, prev_we);
            chk("stall_addr", mem_req_addr_o, prev_addr);
            chk("stall_wdata", mem_req_wdata_o, prev_wdata);
         end
         prev_stall = mem_req_valid_o && !mem_req_ready_i;
         prev_we    = mem_req_we_o;
         prev_addr  = mem_req_addr_o;
         prev_wdata = mem_req_wdata_o;

         mem_resp_valid_i = 1'b0;
         if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_rdata_i = rsp_q[0].data;
            void'(rsp_q.pop_front());
            if (stale_n > 0) stale_n--;
            else             bench_out--;
         end

         if (mem_req_valid_o && mem_req_ready_i) begin
            req_cyc.push_back(cyc);
            chk("req_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               req_t e;
               e = exp_q.pop_front();
               chk("req_we", mem_req_we_o, e.we);
               chk("req_addr", mem_req_addr_o, e.addr);
               chk("req_wdata", mem_req_wdata_o, e.wdata);
            end
            if (!mem_req_we_o) begin
               rsp_q.push_back('{due: cyc + lat, data: rd_of(mem_req_addr_o)});
               bench_out++;
               if (mem_resp_valid_i) overlap++;
            end
         end
      end
   end

   task automatic run_op(input bit st, input logic [63:0] base, input logic [63:0] stride,
                         input logic [LANES-1:0] mask, input int l, input bit stl,
                         input int exp_done, input bit timed);
      logic [63:0] exp_ld [LANES];
      logic [63:0] a, w;
      int t, k, n;
      lat = l;
      stall = stl;
      req_cyc.delete();
      n = 0;
      for (int i = 0; i < LANES; i++) begin
         a = base + 64'(i) * stride;
         w = base ^ (64'(i + 1) * 64'h0101_0101_0101_0101);
         vec_wdata_i[i*EW +: EW] = w;
         exp_ld[i] = (!st && mask[i]) ? rd_of(a) : 64'd0;
         if (mask[i]) begin
            exp_q.push_back('{we: st, addr: a, wdata: st ? w : 64'd0});
            n++;
         end
      end
      @(negedge clk);
      k = 0;
      while (!vec_ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("vec_ready", vec_ready_o, 1'b1);
      vec_valid_i    = 1'b1;
      vec_is_store_i = st;
      vec_base_i     = base;
      vec_stride_i   = stride;
      vec_mask_i     = mask;
      @(negedge clk);
      vec_valid_i = 1'b0;
      t = cyc - 1;
      chk("busy", busy_o, 1'b1);
      k = 0;
      while (!done_o && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", done_o, 1'b1);
      if (exp_done >= 0) chk("done_cyc", 64'(cyc - t), 64'(exp_done));
      if (timed) begin
         chk("req_count", 64'(req_cyc.size()), 64'(n));
         for (int i = 0; i < req_cyc.size(); i++) chk("req_cyc", 64'(req_cyc[i] - t), 64'(i + 1));
      end
      @(negedge clk);
      chk("done_pulse", done_o, 1'b0);
      chk("busy_end", busy_o, 1'b0);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < LANES; i++) chk("load_lane", load_data_o[i*EW +: EW], exp_ld[i]);
   endtask

   task automatic check_idle_outputs();
      chk("rst_vec_ready", vec_ready_o, 1'b1);
      chk("rst_req_valid", mem_req_valid_o, 1'b0);
      chk("rst_req_we", mem_req_we_o, 1'b0);
      chk("rst_req_addr", mem_req_addr_o, 64'd0);
      chk("rst_req_wdata", mem_req_wdata_o, 64'd0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      for (int i = 0; i < LANES; i++) chk("rst_load", load_data_o[i*EW +: EW], 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      check_idle_outputs();
      @(posedge clk);
      #2 rst_n = 1'b1;

      run_op(1'b1, 64'h1000, 64'd8, 8'hFF, 1, 1'b0, LANES + 1, 1'b1);
      run_op(1'b0, 64'h2000, -64'sd16, 8'hA5, 3, 1'b0, -1, 1'b0);
      max_out = 0;
      overlap = 0;
      run_op(1'b0, 64'h3000, 64'd8, 8'hFF, 10, 1'b0, -1, 1'b0);
      chk("max_outstanding", 64'(max_out), 64'(MO));
      chk("req_resp_overlap", 64'(overlap > 0), 64'd1);
      run_op(1'b1, 64'h4000, 64'd24, 8'h5B, 1, 1'b1, -1, 1'b0);
      run_op(1'b0, 64'h4800, -64'sd8, 8'hF7, 2, 1'b1, -1, 1'b0);
      run_op(1'b0, 64'h6000, 64'd8, 8'h00, 1, 1'b0, 2, 1'b1);
      run_op(1'b1, 64'h6000, 64'd8, 8'h00, 1, 1'b0, 2, 1'b1);

      // Abort a load with requests in flight, then let the stragglers arrive while idle.
      lat = 10;
      stall = 1'b0;
      for (int i = 0; i < LANES; i++)
         exp_q.push_back('{we: 1'b0, addr: 64'h7000 + 64'(i) * 64'd8, wdata: 64'd0});
      @(negedge clk);
      vec_valid_i    = 1'b1;
      vec_is_store_i = 1'b0;
      vec_base_i     = 64'h7000;
      vec_stride_i   = 64'd8;
      vec_mask_i     = 8'hFF;
      @(negedge clk);
      vec_valid_i = 1'b0;
      k = 0;
      while (bench_out < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("reached_two_outst", 64'(bench_out >= 2), 64'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      stale_n   = rsp_q.size();
      bench_out = 0;
      @(negedge clk);
      check_idle_outputs();
      @(posedge clk);
      #2 rst_n = 1'b1;
      k = 0;
      while ((rsp_q.size() > 0 || mem_resp_valid_i) && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("stale_drained", 64'(stale_n), 64'd0);
      check_idle_outputs();

      run_op(1'b0, 64'h5000, 64'h40, 8'h3C, 1, 1'b0, -1, 1'b0);
      run_op(1'b1, 64'h5800, 64'd16, 8'h81, 1, 1'b0, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
